// File: rtl/sdram_lock_seq.sv
// DCM reset/lock sequencer: pulses the DCM reset, waits for a stable lock with
// bounded retries, and releases the SDRAM-domain reset only while lock is held.
module sdram_lock_seq #(
    parameter int unsigned RST_PULSE_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT     = 65535,
    parameter int unsigned STABLE_CYCLES    = 256,
    parameter int unsigned MAX_RETRIES      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcm_locked,
    input  logic       restart,
    output logic       dcm_rst,
    output logic       sdram_rst,
    output logic       ready,
    output logic       lock_error,
    output logic [7:0] relock_count
);

    localparam logic [15:0] PULSE_LAST   = 16'(RST_PULSE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PULSE     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  relock_q, relock_d;
    logic        sync1_q, sync2_q;
    logic        dcm_rst_q, sdram_rst_q, ready_q, lock_error_q;
    logic        dcm_rst_d, sdram_rst_d, ready_d, lock_error_d;
    logic        locked_s;

    assign locked_s = sync2_q;

    // Two-flop synchronizer for the asynchronous DCM LOCKED signal
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dcm_locked;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 16'd1;
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            ST_PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = 16'd0;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked first so it wins a same-cycle timeout.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    timer_d = 16'd0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    timer_d = 16'd0;
                    if (retry_d == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_PULSE;
                    timer_d = 16'd0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    timer_d = 16'd0;
                    retry_d = 4'd0;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_RUN: begin
                timer_d = 16'd0;
                if (!locked_s) begin
                    state_d = ST_PULSE;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end else begin
                        relock_d = relock_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL: begin
                timer_d = 16'd0;
                if (restart) begin
                    state_d = ST_PULSE;
                    retry_d = 4'd0;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                state_d = ST_PULSE;
                timer_d = 16'd0;
                retry_d = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        dcm_rst_d    = (state_d == ST_PULSE);
        sdram_rst_d  = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        lock_error_d = (state_d == ST_FAIL);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PULSE;
            timer_q      <= 16'd0;
            retry_q      <= 4'd0;
            relock_q     <= 8'd0;
            dcm_rst_q    <= 1'b1;
            sdram_rst_q  <= 1'b1;
            ready_q      <= 1'b0;
            lock_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            dcm_rst_q    <= dcm_rst_d;
            sdram_rst_q  <= sdram_rst_d;
            ready_q      <= ready_d;
            lock_error_q <= lock_error_d;
        end
    end

    assign dcm_rst      = dcm_rst_q;
    assign sdram_rst    = sdram_rst_q;
    assign ready        = ready_q;
    assign lock_error   = lock_error_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_sdram_lock_seq.sv
// Directed bench for sdram_lock_seq with RST_PULSE_CYCLES=4, LOCK_TIMEOUT=100,
// STABLE_CYCLES=16, MAX_RETRIES=3. Outputs are grouped as {dcm_rst,sdram_rst,ready,lock_error}.
module tb_sdram_lock_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       dcm_locked;
    logic       restart;
    logic       dcm_rst, sdram_rst, ready, lock_error;
    logic [7:0] relock_count;

    int tests = 0;
    int fails = 0;
    int t     = 0;

    sdram_lock_seq #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT    (100),
        .STABLE_CYCLES   (16),
        .MAX_RETRIES     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dcm_locked  (dcm_locked),
        .restart     (restart),
        .dcm_rst     (dcm_rst),
        .sdram_rst   (sdram_rst),
        .ready       (ready),
        .lock_error  (lock_error),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic tick_to(input int target);
        while (t < target) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; dcm_locked = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b1100 || relock_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_values got=%b/%0d exp=1100/0", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
        rst = 1'b1;
        t = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests++;
            if (dcm_rst !== 1'b1) begin
                fails++;
                $display("FAIL release_pulse_edge%0d got=%b exp=1", k, dcm_rst);
            end
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL release_pulse_end got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
    endtask

    task automatic test_lock_up();
        tick_to(19);
        dcm_locked = 1'b1;
        tick_to(37);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL lockup_before_run got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0010 || relock_count !== 8'd0) begin
            fails++;
            $display("FAIL lockup_run_at38 got=%b/%0d exp=0010/0", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
    endtask

    task automatic test_run_drop();
        t = 0;
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        tick();
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL drop_sync_latency got=%b exp=1", ready);
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b1100 || relock_count !== 8'd1) begin
            fails++;
            $display("FAIL drop_to_pulse got=%b/%0d exp=1100/1", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
        tick_to(7);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL drop_pulse_end got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick_to(23);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL drop_early_run got=%b exp=0", ready);
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0010) begin
            fails++;
            $display("FAIL drop_rerun got=%b exp=0010", {dcm_rst, sdram_rst, ready, lock_error});
        end
    endtask

    task automatic test_stable_glitch();
        t = 0;
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        tick_to(15);
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        tick_to(17);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL glitch_in_stable got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b1100 || relock_count !== 8'd2) begin
            fails++;
            $display("FAIL glitch_to_pulse got=%b/%0d exp=1100/2", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
        tick_to(24);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL glitch_no_old_run got=%b exp=0", ready);
        end
        tick_to(38);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL glitch_fresh_count got=%b exp=0", ready);
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0010 || relock_count !== 8'd2) begin
            fails++;
            $display("FAIL glitch_run got=%b/%0d exp=0010/2", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
    endtask

    task automatic test_timeout_fail();
        t = 0;
        dcm_locked = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                tick_to(2 + 104 * k);
                tests++;
                if (dcm_rst !== 1'b0) begin
                    fails++;
                    $display("FAIL retry%0d_pre_pulse got=%b exp=0", k, dcm_rst);
                end
            end
            tick_to(3 + 104 * k);
            tests++;
            if (dcm_rst !== 1'b1 || relock_count !== 8'd3) begin
                fails++;
                $display("FAIL retry%0d_pulse got=%b/%0d exp=1/3", k, dcm_rst, relock_count);
            end
            tick_to(7 + 104 * k);
            tests++;
            if ({dcm_rst, lock_error} !== 2'b00) begin
                fails++;
                $display("FAIL retry%0d_pulse_end got=%b exp=00", k, {dcm_rst, lock_error});
            end
        end
        tick_to(314);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL fail_early got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0101) begin
            fails++;
            $display("FAIL fail_entry got=%b exp=0101", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick_to(330);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0101) begin
            fails++;
            $display("FAIL fail_hold got=%b exp=0101", {dcm_rst, sdram_rst, ready, lock_error});
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b1100 || relock_count !== 8'd3) begin
            fails++;
            $display("FAIL restart got=%b/%0d exp=1100/3", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
    endtask

    task automatic test_timeout_race();
        tick_to(432);
        dcm_locked = 1'b1;
        tick_to(434);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL race_wait got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL race_lock_wins got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        tick_to(450);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL race_stable got=%b exp=0", ready);
        end
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0010) begin
            fails++;
            $display("FAIL race_run got=%b exp=0010", {dcm_rst, sdram_rst, ready, lock_error});
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0010) begin
            fails++;
            $display("FAIL restart_ignored_in_run got=%b exp=0010", {dcm_rst, sdram_rst, ready, lock_error});
        end
    endtask

    task automatic test_relock_saturate();
        int exp_cnt;
        exp_cnt = 3;
        for (int k = 0; k < 256; k++) begin
            t = 0;
            dcm_locked = 1'b0;
            tick();
            dcm_locked = 1'b1;
            tick_to(3);
            if (exp_cnt < 255) exp_cnt++;
            tests++;
            if (relock_count !== 8'(exp_cnt)) begin
                fails++;
                $display("FAIL relock_drop%0d got=%0d exp=%0d", k, relock_count, exp_cnt);
            end
            tick_to(25);
        end
        tests++;
        if (relock_count !== 8'd255 || ready !== 1'b1) begin
            fails++;
            $display("FAIL relock_saturated got=%0d/%b exp=255/1", relock_count, ready);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b1100 || relock_count !== 8'd0) begin
            fails++;
            $display("FAIL async_rst_run got=%b/%0d exp=1100/0", {dcm_rst, sdram_rst, ready, lock_error}, relock_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        dcm_locked = 1'b0;
        t = 0;
        tick_to(10);
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b0100) begin
            fails++;
            $display("FAIL async_pre_wait got=%b exp=0100", {dcm_rst, sdram_rst, ready, lock_error});
        end
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if ({dcm_rst, sdram_rst, ready, lock_error} !== 4'b1100) begin
            fails++;
            $display("FAIL async_rst_wait got=%b exp=1100", {dcm_rst, sdram_rst, ready, lock_error});
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_run_drop();
        test_stable_glitch();
        test_timeout_fail();
        test_timeout_race();
        test_relock_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
